// File: rtl/nlynx_pkg.sv
// Shared constants, FSM state type and header packing helper for the NLYNX frame streamer.
package nlynx_pkg;

    localparam int NLYNX_WORD_WIDTH = 32;

    localparam int HDR_DROP_LSB = 24;
    localparam int HDR_DROP_MSB = 31;
    localparam int HDR_SEQ_LSB  = 16;
    localparam int HDR_SEQ_MSB  = 23;
    localparam int HDR_OVF_LSB  = 0;
    localparam int HDR_OVF_MSB  = 15;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        CNT
    } nlynx_state_e;

    function automatic logic [NLYNX_WORD_WIDTH-1:0] nlynx_header(
        input logic [7:0]  drop_cnt,
        input logic [7:0]  seq,
        input logic [15:0] ovf
    );
        logic [NLYNX_WORD_WIDTH-1:0] word;
        word                             = '0;
        word[HDR_DROP_MSB:HDR_DROP_LSB]  = drop_cnt;
        word[HDR_SEQ_MSB:HDR_SEQ_LSB]    = seq;
        word[HDR_OVF_MSB:HDR_OVF_LSB]    = ovf;
        return word;
    endfunction

endpackage

// File: rtl/nlynx_frame_fifo.sv
// Small synchronous frame FIFO; exposes the head entry and the tag bits of the entry behind it.
module nlynx_frame_fifo
    import nlynx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int TAG_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head_data,
    output logic [TAG_W-1:0]           head_next_tag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [CNT_W-1:0] count_reg;

    assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // The caller only pushes into a full FIFO when it pops on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign full          = (count_reg == CNT_W'(DEPTH));
    assign empty         = (count_reg == '0);
    assign count         = count_reg;
    assign head_data     = mem[rd_ptr_reg];
    assign head_next_tag = mem[rd_ptr_inc][WIDTH-1 -: TAG_W];

endmodule

// File: rtl/nlynx_frame_streamer.sv
// Snapshots NLYNX counters on end-of-period into a frame FIFO and streams each frame as 32-bit words.
module nlynx_frame_streamer
    import nlynx_pkg::*;
#(
    parameter int NLYNX_METRICS       = 13,
    parameter int NLYNX_COUNTER_WIDTH = 32,
    parameter int FRAME_DEPTH         = 2
) (
    input  logic                                                clk_i,
    input  logic                                                rst_i,
    input  logic                                                enable_i,
    input  logic [NLYNX_METRICS-1:0][NLYNX_COUNTER_WIDTH-1:0]   nlynx_counters_i,
    input  logic [NLYNX_METRICS-1:0]                            nlynx_overflow_i,
    input  logic                                                nlynx_eop_i,
    output logic                                                out_valid_o,
    input  logic                                                out_ready_i,
    output logic [NLYNX_WORD_WIDTH-1:0]                         out_data_o,
    output logic                                                out_last_o,
    output logic [$clog2(FRAME_DEPTH):0]                        frames_pending_o,
    output logic                                                drop_o
);

    localparam int M       = NLYNX_METRICS;
    localparam int CW      = NLYNX_COUNTER_WIDTH;
    localparam int TAG_W   = M + 8;
    localparam int ENTRY_W = M * CW + TAG_W;
    localparam int CNT_W   = $clog2(FRAME_DEPTH) + 1;
    localparam int IDX_W   = (M > 1) ? $clog2(M) : 1;

    nlynx_state_e                state_reg, state_next;
    logic [IDX_W-1:0]            idx_reg, idx_next;
    logic                        out_valid_reg, out_valid_next;
    logic                        out_last_reg, out_last_next;
    logic [NLYNX_WORD_WIDTH-1:0] out_data_reg, out_data_next;
    logic                        drop_reg;
    logic [7:0]                  seq_reg, seq_next;
    logic [7:0]                  drop_cnt_reg, drop_cnt_next, drop_base;

    logic                        capture, push, pop, drop, hs, hdr_hs;
    logic                        fifo_full, fifo_empty;
    logic [CNT_W-1:0]            fifo_count;
    logic [ENTRY_W-1:0]          push_data, head_data;
    logic [TAG_W-1:0]            next_tag;

    logic [CW-1:0]               head_cnt [M];
    logic [M-1:0]                head_ovf, next_ovf;
    logic [7:0]                  head_seq, next_seq;

    assign push_data = {seq_reg, nlynx_overflow_i, nlynx_counters_i};

    nlynx_frame_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FRAME_DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk           (clk_i),
        .rst           (rst_i),
        .push          (push),
        .pop           (pop),
        .wr_data       (push_data),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .count         (fifo_count),
        .head_data     (head_data),
        .head_next_tag (next_tag)
    );

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_head_cnt
            assign head_cnt[gi] = head_data[gi*CW +: CW];
        end
    endgenerate

    assign head_ovf = head_data[M*CW +: M];
    assign head_seq = head_data[M*CW+M +: 8];
    assign next_ovf = next_tag[M-1:0];
    assign next_seq = next_tag[TAG_W-1 -: 8];

    assign hs      = out_valid_reg && out_ready_i;
    assign hdr_hs  = (state_reg == HDR) && hs;
    assign pop     = (state_reg == CNT) && hs && out_last_reg;

    // A pop on the same edge frees the slot, so a capture against a full FIFO still lands.
    assign capture = nlynx_eop_i && enable_i;
    assign push    = capture && (!fifo_full || pop);
    assign drop    = capture && fifo_full && !pop;

    assign seq_next      = seq_reg + 8'(push);
    assign drop_base     = hdr_hs ? 8'd0 : drop_cnt_reg;
    assign drop_cnt_next = drop ? ((drop_base == 8'hFF) ? 8'hFF : drop_base + 8'd1) : drop_base;

    // A header waiting on ready keeps its drop field tracking drop_cnt, so the accepted
    // header carries every drop up to its handshake; seq and overflow never move.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next     = HDR;
                    out_valid_next = 1'b1;
                    out_data_next  = nlynx_header(drop_cnt_next, head_seq, 16'(head_ovf));
                    out_last_next  = 1'b0;
                end
            end
            HDR: begin
                if (hs) begin
                    state_next    = CNT;
                    idx_next      = '0;
                    out_data_next = 32'(head_cnt[0]);
                    out_last_next = (M == 1);
                end else begin
                    out_data_next = nlynx_header(drop_cnt_next, head_seq, 16'(head_ovf));
                end
            end
            CNT: begin
                if (hs) begin
                    if (out_last_reg) begin
                        if (fifo_count > CNT_W'(1)) begin
                            state_next     = HDR;
                            out_valid_next = 1'b1;
                            out_data_next  = nlynx_header(drop_cnt_next, next_seq, 16'(next_ovf));
                        end else begin
                            state_next     = IDLE;
                            out_valid_next = 1'b0;
                            out_data_next  = '0;
                        end
                        out_last_next = 1'b0;
                    end else begin
                        idx_next      = idx_reg + IDX_W'(1);
                        out_data_next = 32'(head_cnt[idx_next]);
                        out_last_next = (idx_next == IDX_W'(M - 1));
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            drop_reg      <= 1'b0;
            seq_reg       <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_last_reg  <= out_last_next;
            drop_reg      <= drop;
            seq_reg       <= seq_next;
            drop_cnt_reg  <= drop_cnt_next;
        end
    end

    assign out_valid_o      = out_valid_reg;
    assign out_data_o       = out_data_reg;
    assign out_last_o       = out_last_reg;
    assign drop_o           = drop_reg;
    assign frames_pending_o = fifo_count;

endmodule
